iob_eth_mdio_ctrl: RTL and testbench
====================================

# iob_eth_mdio_ctrl

MII management (MDIO) frame engine for the Ethernet core. Accepts single read/write register requests over a valid/ready handshake, generates MDC from `clk_i` and serialises an IEEE 802.3 clause-22 frame onto MDIO. It returns read data and a no-PHY error flag. It sits between the core's CSR block and the MII management pad logic, and drives the `mii_mdc_o`/`mii_mdio_io` pins of `iob_eth_mii_management`.

## Interface
- `CLK_DIV`, 10: MDC half-period in `clk_i` cycles; legal range ≥1.
- `clk_i` in 1: system clock.
- `arst_n_i` in 1: asynchronous active-low reset.
- `cke_i` in 1: clock enable; when low all state is frozen.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: engine idle, can accept a request.
- `req_write_i` in 1: 1 selects write, 0 selects read.
- `req_phy_addr_i` in 5: PHY address.
- `req_reg_addr_i` in 5: register address.
- `req_wdata_i` in 16: write data.
- `rsp_valid_o` out 1: one-cycle completion pulse.
- `rsp_rdata_o` out 16: read data; 0 after a write.
- `rsp_err_o` out 1: read turnaround bit was not driven 0 by the PHY.
- `busy_o` out 1: transaction in progress.
- `mdc_o` out 1: management clock.
- `mdio_o` out 1: MDIO output value.
- `mdio_oe_o` out 1: MDIO output enable. The pad wrapper drives `mii_mdio_io` from this.
- `mdio_i` in 1: MDIO input from the pad.

## Operation
- States: IDLE, PRE, FRAME, RESP.
- `req_ready_o` = (state==IDLE). `busy_o` = !req_ready_o.
- IDLE: on `req_valid_i && req_ready_o`, latch all request fields and go to PRE. If `IOB_ETH_MDIO_NOPRE_EN` applies and `nopre_i` is high, go to FRAME instead.
- PRE: 32 bits of 1 with `mdio_oe_o`=1.
- FRAME: 32 bits, MSB first:
  - ST=01.
  - OP=01 for write, 10 for read.
  - PHYAD[4:0], REGAD[4:0].
  - TA: write drives 10. Read releases the line (`mdio_oe_o`=0) for both TA bits.
  - DATA[15:0]: write drives wdata. Read keeps `mdio_oe_o`=0.
- Read sampling: `mdio_i` is sampled on the clk cycle in which `mdc_o` rises.
  - Second TA bit sampled as 1 sets `rsp_err_o`.
  - Data bits shift into a 16-bit register, MSB first.
- RESP: one cycle. `rsp_valid_o`=1, `mdio_oe_o`=0, `mdc_o`=0. Then return to IDLE.
- `rsp_rdata_o`/`rsp_err_o` hold their value until the next RESP.
- Requests arriving while busy are not accepted. The requester holds `req_valid_i`.
- Async reset mid-transaction: the frame is aborted immediately with no response. The PHY recovers through the next preamble.
- `cke_i` low: counters, MDC and shift registers hold.

## Timing
- Reset values:
  - `mdc_o`=0, `mdio_o`=1, `mdio_oe_o`=0.
  - `req_ready_o`=1, `busy_o`=0.
  - `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0.
- Bit timing: each bit lasts 2·CLK_DIV cycles.
  - MDC is low for the first CLK_DIV cycles and high for the next CLK_DIV.
  - `mdio_o`/`mdio_oe_o` change only at bit start, i.e. MDC falling edge or first bit.
- The first bit starts in the cycle after acceptance.
- Latency from acceptance to `rsp_valid_o`:
  - 64·2·CLK_DIV+1 cycles with preamble.
  - 32·2·CLK_DIV+1 cycles without preamble.
- Next acceptance is possible the cycle after RESP.

## Configuration
- `IOB_ETH_MDIO_NOPRE_EN` defined:
  - Adds input `nopre_i` (1 bit), sampled at acceptance.
  - When `nopre_i` is 1, PRE is skipped.
- Undefined: no `nopre_i` port; every frame carries the 32-bit preamble.

## Structure
- `iob_eth_mdio_ctrl_conf.vh` holds:
  - state encodings;
  - ST/OP codes;
  - PRE_BITS=32, FRAME_BITS=32;
  - the CLK_DIV default.
- Sub-module `iob_eth_mdio_clkgen`: MDC divider.
  - Outputs `mdc_o` plus one-cycle `rise_o`/`fall_o` strobes.
  - Enabled only while busy.
  - Counter width is $clog2(CLK_DIV+1).

## Test plan
- CLK_DIV=2, write phy=5'h01 reg=5'h00 data=16'h1140 → the 64 MDIO bits decoded at MDC rising edges are 32×1, 01, 01, 00001, 00000, 10, 1140h. `rsp_valid_o` arrives at cycle 257. `mdio_oe_o` stays 1 throughout.
- Read phy=3 reg=2; the PHY model drives TA-bit 0 then 16'h0022 → `rsp_rdata_o`=16'h0022, `rsp_err_o`=0. `mdio_oe_o` is 0 from the first TA bit.
- Read with `mdio_i` held 1 (no PHY) → `rsp_err_o`=1, `rsp_rdata_o`=16'hFFFF.
- Back-to-back requests with `req_valid_i` held high → the second request is accepted the cycle after the first `rsp_valid_o`, and `req_ready_o` is 0 in between.
- `arst_n_i` pulsed at bit 40 → all outputs take reset values immediately and no `rsp_valid_o` is produced. A new request then runs a full frame correctly.
- With `IOB_ETH_MDIO_NOPRE_EN` and `nopre_i`=1, CLK_DIV=1 → `rsp_valid_o` at cycle 65. With `cke_i` low for 10 cycles mid-frame, latency grows by exactly 10.

Source files
------------

// File: rtl/iob_eth_mdio_ctrl_pkg.sv
// iob_eth_mdio_ctrl_pkg
// Shared configuration for the MDIO frame engine: FSM state encoding,
// clause-22 ST/OP/TA codes, phase lengths, the default MDC divider and
// a helper that assembles the 32-bit management frame.
// Optional feature macro used by the top: IOB_ETH_MDIO_NOPRE_EN.
package iob_eth_mdio_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRE   = 2'd1,
        ST_FRAME = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_TA_WR = 2'b10;

    localparam int PRE_BITS    = 32;
    localparam int FRAME_BITS  = 32;
    localparam int CLK_DIV_DEF = 10;

    // Bit positions inside the frame (0 = first bit on the wire)
    localparam int TA_IDX   = 14;
    localparam int DATA_IDX = 16;

    // Frame word, MSB transmitted first. For reads the TA/DATA field is
    // zero-filled and unused: the line is released there.
    function automatic logic [31:0] mdio_frame(input logic        wr,
                                               input logic [4:0]  phy,
                                               input logic [4:0]  regad,
                                               input logic [15:0] wdata);
        return {MDIO_ST, (wr ? MDIO_OP_WR : MDIO_OP_RD), phy, regad,
                (wr ? MDIO_TA_WR : 2'b00), (wr ? wdata : 16'h0000)};
    endfunction

endpackage

// File: rtl/iob_eth_mdio_clkgen.sv
// iob_eth_mdio_clkgen
// MDC divider. MDC is low for CLK_DIV cycles then high for CLK_DIV cycles,
// starting low in the first enabled cycle.
// Ports:
//   clk_i, arst_n_i  clock / async active-low reset
//   cke_i            clock enable, freezes counter and MDC when low
//   en_i             run the divider; when low MDC is parked low
//   mdc_o            management clock (registered)
//   rise_o, fall_o   high in the cycle whose closing edge raises/lowers MDC
module iob_eth_mdio_clkgen #(
    parameter int CLK_DIV = 10
) (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic cke_i,
    input  logic en_i,
    output logic mdc_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          last;

    assign last   = (cnt == CNT_MAX);
    assign rise_o = en_i && cke_i && last && !mdc_o;
    assign fall_o = en_i && cke_i && last && mdc_o;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cnt   <= '0;
            mdc_o <= 1'b0;
        end else if (cke_i) begin
            if (!en_i) begin
                cnt   <= '0;
                mdc_o <= 1'b0;
            end else if (last) begin
                cnt   <= '0;
                mdc_o <= !mdc_o;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/iob_eth_mdio_ctrl.sv
// iob_eth_mdio_ctrl
// Clause-22 MDIO frame engine: accepts one read/write request, sends an
// optional 32-bit preamble and a 32-bit frame, samples read data on MDC
// rising edges and returns a one-cycle response.
// Ports:
//   clk_i, arst_n_i, cke_i            clock, async active-low reset, enable
//   req_valid_i/req_ready_o           request handshake
//   req_write_i, req_phy_addr_i,
//   req_reg_addr_i, req_wdata_i       request fields
//   nopre_i                           skip preamble (IOB_ETH_MDIO_NOPRE_EN only)
//   rsp_valid_o, rsp_rdata_o, rsp_err_o  completion pulse, read data, no-PHY flag
//   busy_o                            transaction in progress
//   mdc_o, mdio_o, mdio_oe_o, mdio_i  management pins
// Macro: IOB_ETH_MDIO_NOPRE_EN adds nopre_i.
module iob_eth_mdio_ctrl
    import iob_eth_mdio_ctrl_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic        clk_i,
    input  logic        arst_n_i,
    input  logic        cke_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [4:0]  req_phy_addr_i,
    input  logic [4:0]  req_reg_addr_i,
    input  logic [15:0] req_wdata_i,
`ifdef IOB_ETH_MDIO_NOPRE_EN
    input  logic        nopre_i,
`endif
    output logic        rsp_valid_o,
    output logic [15:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic        mdc_o,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic        mdio_i
);

    state_t      state;
    logic        wr_q;
    logic [31:0] tx;
    logic [15:0] rx;
    logic        rx_err;
    logic [4:0]  bit_cnt;
    logic        skip_pre;
    logic        mdc_en;
    logic        mdc_rise;
    logic        mdc_fall;

`ifdef IOB_ETH_MDIO_NOPRE_EN
    assign skip_pre = nopre_i;
`else
    assign skip_pre = 1'b0;
`endif

    assign req_ready_o = (state == ST_IDLE);
    assign busy_o      = !req_ready_o;
    assign mdc_en      = (state == ST_PRE) || (state == ST_FRAME);

    iob_eth_mdio_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .cke_i    (cke_i),
        .en_i     (mdc_en),
        .mdc_o    (mdc_o),
        .rise_o   (mdc_rise),
        .fall_o   (mdc_fall)
    );

    // Bits advance on the MDC falling strobe so mdio_o/mdio_oe_o only
    // change at bit start; read data is captured on the rising strobe.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state       <= ST_IDLE;
            wr_q        <= 1'b0;
            tx          <= '0;
            rx          <= '0;
            rx_err      <= 1'b0;
            bit_cnt     <= '0;
            mdio_o      <= 1'b1;
            mdio_oe_o   <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else if (cke_i) begin
            rsp_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        wr_q      <= req_write_i;
                        tx        <= mdio_frame(req_write_i, req_phy_addr_i,
                                                req_reg_addr_i, req_wdata_i);
                        rx        <= '0;
                        rx_err    <= 1'b0;
                        bit_cnt   <= '0;
                        mdio_oe_o <= 1'b1;
                        if (skip_pre) begin
                            state  <= ST_FRAME;
                            mdio_o <= MDIO_ST[1];
                        end else begin
                            state  <= ST_PRE;
                            mdio_o <= 1'b1;
                        end
                    end
                end
                ST_PRE: begin
                    if (mdc_fall) begin
                        if (bit_cnt == 5'(PRE_BITS - 1)) begin
                            state   <= ST_FRAME;
                            bit_cnt <= '0;
                            mdio_o  <= tx[31];
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                ST_FRAME: begin
                    if (mdc_rise && !wr_q) begin
                        // A PHY pulls the second TA bit low; a floating
                        // (pulled-up) line means nobody answered.
                        if (bit_cnt == 5'(TA_IDX + 1))
                            rx_err <= mdio_i;
                        else if (bit_cnt >= 5'(DATA_IDX))
                            rx <= {rx[14:0], mdio_i};
                    end
                    if (mdc_fall) begin
                        if (bit_cnt == 5'(FRAME_BITS - 1)) begin
                            state       <= ST_RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_rdata_o <= wr_q ? 16'h0000 : rx;
                            rsp_err_o   <= wr_q ? 1'b0 : rx_err;
                            mdio_o      <= 1'b1;
                            mdio_oe_o   <= 1'b0;
                        end else begin
                            bit_cnt   <= bit_cnt + 5'd1;
                            tx        <= {tx[30:0], 1'b0};
                            mdio_o    <= tx[30];
                            // reads release the line from the first TA bit
                            mdio_oe_o <= wr_q || (bit_cnt < 5'(TA_IDX - 1));
                        end
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_eth_mdio_ctrl.sv
module tb_iob_eth_mdio_ctrl;

    localparam int CLK_DIV = 2;
    localparam int LAT_PRE = 64 * 2 * CLK_DIV + 1;   // 257

    logic        clk_i = 1'b0;
    logic        arst_n_i = 1'b0;
    logic        cke_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_write_i = 1'b0;
    logic [4:0]  req_phy_addr_i = '0;
    logic [4:0]  req_reg_addr_i = '0;
    logic [15:0] req_wdata_i = '0;
    logic        nopre = 1'b0;
    logic        rsp_valid_o;
    logic [15:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic        mdc_o;
    logic        mdio_o;
    logic        mdio_oe_o;
    logic        mdio_i;

    always #5 clk_i = ~clk_i;

    iob_eth_mdio_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk_i          (clk_i),
        .arst_n_i       (arst_n_i),
        .cke_i          (cke_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_write_i    (req_write_i),
        .req_phy_addr_i (req_phy_addr_i),
        .req_reg_addr_i (req_reg_addr_i),
        .req_wdata_i    (req_wdata_i),
`ifdef IOB_ETH_MDIO_NOPRE_EN
        .nopre_i        (nopre),
`endif
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .busy_o         (busy_o),
        .mdc_o          (mdc_o),
        .mdio_o         (mdio_o),
        .mdio_oe_o      (mdio_oe_o),
        .mdio_i         (mdio_i)
    );

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        logic [63:0] bits;   // driven bits (0 where released), MSB = first bit
        logic [63:0] oe;
        int          lat;
        int          gap;    // required cycles from previous rsp to busy rise, 0 = skip
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // monitor state
    int          cyc = 0;
    int          lat = 0;
    int          rise_cnt = 0;
    int          rsp_cnt = 0;
    int          last_rsp_cyc = 0;
    logic [63:0] cap = '0;
    logic [63:0] cap_oe = '0;

    // PHY model
    logic        phy_on = 1'b0;
    logic [15:0] phy_data = '0;

    always_comb begin
        mdio_i = 1'b1;
        if (phy_on && rise_cnt == 47)
            mdio_i = 1'b0;
        else if (phy_on && rise_cnt >= 48 && rise_cnt <= 63)
            mdio_i = phy_data[4'(63 - rise_cnt)];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] rdata, input logic err,
                                input logic [63:0] bits, input logic [63:0] oe,
                                input int lat_e, input int gap);
        exp_t e;
        e.rdata = rdata; e.err = err; e.bits = bits; e.oe = oe;
        e.lat = lat_e; e.gap = gap;
        return e;
    endfunction

    // Monitor / scoreboard
    initial begin
        logic prev_mdc;
        logic prev_busy;
        exp_t e;
        prev_mdc = 1'b0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (busy_o && !prev_busy) begin
                lat = 1; rise_cnt = 0; cap = '0; cap_oe = '0;
                if (q.size() > 0 && q[0].gap > 0)
                    chk("accept_gap", 64'(cyc - last_rsp_cyc), 64'(q[0].gap));
            end else if (busy_o) begin
                lat++;
            end
            if (mdc_o && !prev_mdc) begin
                cap    = {cap[62:0], mdio_o & mdio_oe_o};
                cap_oe = {cap_oe[62:0], mdio_oe_o};
                rise_cnt++;
            end
            if (rsp_valid_o) begin
                rsp_cnt++;
                last_rsp_cyc = cyc;
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 64'(1), 64'(0));
                end else begin
                    e = q.pop_front();
                    chk("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
                    chk("rsp_err", 64'(rsp_err_o), 64'(e.err));
                    chk("mdio_bits", cap, e.bits);
                    chk("mdio_oe", cap_oe, e.oe);
                    chk("latency", 64'(lat), 64'(e.lat));
                    chk("ready_in_resp", 64'(req_ready_o), 64'(0));
                end
            end
            prev_mdc = mdc_o;
            prev_busy = busy_o;
        end
    end

    task automatic issue(input logic wr, input logic [4:0] phy, input logic [4:0] regad,
                         input logic [15:0] wd);
        int n;
        @(negedge clk_i);
        req_write_i = wr; req_phy_addr_i = phy; req_reg_addr_i = regad; req_wdata_i = wd;
        req_valid_i = 1'b1;
        n = 0;
        while (!req_ready_o && n < 2000) begin @(negedge clk_i); n++; end
        if (n >= 2000) chk("accept_timeout", 64'(1), 64'(0));
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() > 0 && n < 5000) begin @(negedge clk_i); n++; end
        if (q.size() > 0) begin
            chk("rsp_timeout", 64'(q.size()), 64'(0));
            q.delete();
        end
        repeat (3) @(negedge clk_i);
    endtask

    task automatic wait_bits(input int k);
        int n;
        n = 0;
        while (rise_cnt < k && n < 5000) begin @(negedge clk_i); n++; end
        if (n >= 5000) chk("bit_wait_timeout", 64'(rise_cnt), 64'(k));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mdc"},       64'(mdc_o), 64'(0));
        chk({tag, "_mdio"},      64'(mdio_o), 64'(1));
        chk({tag, "_mdio_oe"},   64'(mdio_oe_o), 64'(0));
        chk({tag, "_ready"},     64'(req_ready_o), 64'(1));
        chk({tag, "_busy"},      64'(busy_o), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'(0));
        chk({tag, "_rdata"},     64'(rsp_rdata_o), 64'(0));
        chk({tag, "_err"},       64'(rsp_err_o), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        #23;
        chk_reset_vals("reset");
        @(negedge clk_i);
        arst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // write phy 1 reg 0 data 1140: frame 0101_00001_00000_10_1140
        q.push_back(mk(16'h0000, 1'b0, {32'hFFFF_FFFF, 32'h5082_1140}, 64'hFFFF_FFFF_FFFF_FFFF, LAT_PRE, 0));
        issue(1'b1, 5'h01, 5'h00, 16'h1140);
        wait_done();

        // read phy 3 reg 2, PHY answers 0x0022: header 0110_00011_00010
        phy_on = 1'b1; phy_data = 16'h0022;
        q.push_back(mk(16'h0022, 1'b0, {32'hFFFF_FFFF, 32'h6188_0000}, {32'hFFFF_FFFF, 32'hFFFC_0000}, LAT_PRE, 0));
        issue(1'b0, 5'h03, 5'h02, 16'h0000);
        wait_done();

        // read with no PHY: line floats high
        phy_on = 1'b0;
        q.push_back(mk(16'hFFFF, 1'b1, {32'hFFFF_FFFF, 32'h6F84_0000}, {32'hFFFF_FFFF, 32'hFFFC_0000}, LAT_PRE, 0));
        issue(1'b0, 5'h1F, 5'h01, 16'h0000);
        wait_done();

        // back-to-back writes with valid held high
        q.push_back(mk(16'h0000, 1'b0, {32'hFFFF_FFFF, 32'h5082_1140}, 64'hFFFF_FFFF_FFFF_FFFF, LAT_PRE, 0));
        q.push_back(mk(16'h0000, 1'b0, {32'hFFFF_FFFF, 32'h597E_A5C3}, 64'hFFFF_FFFF_FFFF_FFFF, LAT_PRE, 2));
        @(negedge clk_i);
        req_write_i = 1'b1; req_phy_addr_i = 5'h01; req_reg_addr_i = 5'h00; req_wdata_i = 16'h1140;
        req_valid_i = 1'b1;
        @(negedge clk_i);
        req_phy_addr_i = 5'h12; req_reg_addr_i = 5'h1F; req_wdata_i = 16'hA5C3;
        n0 = 0;
        while (!req_ready_o && n0 < 2000) begin @(negedge clk_i); n0++; end
        @(negedge clk_i);
        req_valid_i = 1'b0;
        wait_done();

        // async reset in the middle of a read at bit 40
        phy_on = 1'b1; phy_data = 16'h1234;
        issue(1'b0, 5'h03, 5'h02, 16'h0000);
        wait_bits(40);
        n0 = rsp_cnt;
        arst_n_i = 1'b0;
        #1;
        chk_reset_vals("abort");
        @(negedge clk_i);
        arst_n_i = 1'b1;
        repeat (300) @(negedge clk_i);
        chk("abort_no_rsp", 64'(rsp_cnt), 64'(n0));

        // full frame after the abort
        phy_data = 16'hBEEF;
        q.push_back(mk(16'hBEEF, 1'b0, {32'hFFFF_FFFF, 32'h6188_0000}, {32'hFFFF_FFFF, 32'hFFFC_0000}, LAT_PRE, 0));
        issue(1'b0, 5'h03, 5'h02, 16'h0000);
        wait_done();
        phy_on = 1'b0;

        // clock enable low for 10 cycles mid-frame stretches latency by 10
        q.push_back(mk(16'h0000, 1'b0, {32'hFFFF_FFFF, 32'h597E_A5C3}, 64'hFFFF_FFFF_FFFF_FFFF, LAT_PRE + 10, 0));
        issue(1'b1, 5'h12, 5'h1F, 16'hA5C3);
        wait_bits(20);
        cke_i = 1'b0;
        repeat (10) @(negedge clk_i);
        cke_i = 1'b1;
        wait_done();

`ifdef IOB_ETH_MDIO_NOPRE_EN
        // no preamble: 32 bits only
        nopre = 1'b1;
        q.push_back(mk(16'h0000, 1'b0, {32'h0, 32'h5082_1140}, {32'h0, 32'hFFFF_FFFF}, 32 * 2 * CLK_DIV + 1, 0));
        issue(1'b1, 5'h01, 5'h00, 16'h1140);
        wait_done();
        nopre = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
